// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its sequencer.
package usr_pkg;

  // Universal shift register mode select values.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StShift = 2'b10,
    StDone  = 2'b11
  } state_e;

endpackage

// File: rtl/usr_sequencer.sv
// Sequencer driving a universal shift register: loads a word, issues N shifts
// (right or left, rotate or fill) and collects the bits shifted out.
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_dir,
  input  logic          in_rot,
  input  logic          in_fill,
  input  logic [CW-1:0] in_cnt,
  input  logic          sr_out,
  input  logic          sl_out,
  output logic [1:0]    s,
  output logic [W-1:0]  i,
  output logic          SR,
  output logic          SL,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  ser_data
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] shift_q, shift_d;
  logic [W-1:0]  data_q, data_d;
  logic          dir_q, dir_d;
  logic          rot_q, rot_d;
  logic          fill_q, fill_d;
  logic [W-1:0]  ser_q, ser_d;
  logic          out_bit;

  // Bit leaving the register on the current shift.
  assign out_bit = dir_q ? sl_out : sr_out;

  // State and job-field registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      fill_q  <= 1'b0;
      ser_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      fill_q  <= fill_d;
      ser_q   <= ser_d;
    end
  end

  // Next-state: job acceptance, shift counting and serial-out capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    fill_d  = fill_q;
    ser_d   = ser_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          dir_d   = in_dir;
          rot_d   = in_rot;
          fill_d  = in_fill;
          // More than W shifts is meaningless; clamp at accept time.
          cnt_d   = (in_cnt > CW'(W)) ? CW'(W) : in_cnt;
          shift_d = '0;
          ser_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        shift_d = '0;
        state_d = (cnt_q != '0) ? StShift : StDone;
      end
      StShift: begin
        ser_d   = ser_q | ({{(W-1){1'b0}}, out_bit} << shift_q);
        shift_d = shift_q + CW'(1);
        if (shift_q == cnt_q - CW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Register control and handshake outputs decoded from the state.
  always_comb begin
    s        = MODE_HOLD;
    i        = data_q;
    SR       = 1'b0;
    SL       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
      end
      StLoad: begin
        s    = MODE_LOAD;
        busy = 1'b1;
      end
      StShift: begin
        s    = dir_q ? MODE_SHL : MODE_SHR;
        SR   = rot_q ? sr_out : fill_q;
        SL   = rot_q ? sl_out : fill_q;
        busy = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  assign ser_data = ser_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// Bench for usr_sequencer paired with a behavioural universal shift register.
`timescale 1ns/1ps
module tb_usr_sequencer;
  import usr_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_dir = 1'b0;
  logic          in_rot = 1'b0;
  logic          in_fill = 1'b0;
  logic [CW-1:0] in_cnt = '0;
  logic          sr_out;
  logic          sl_out;
  logic [1:0]    s;
  logic [W-1:0]  i;
  logic          SR;
  logic          SL;
  logic          busy;
  logic          done;
  logic [W-1:0]  ser_data;

  int checks = 0;
  int errors = 0;

  usr_sequencer #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .in_rot   (in_rot),
    .in_fill  (in_fill),
    .in_cnt   (in_cnt),
    .sr_out   (sr_out),
    .sl_out   (sl_out),
    .s        (s),
    .i        (i),
    .SR       (SR),
    .SL       (SL),
    .busy     (busy),
    .done     (done),
    .ser_data (ser_data)
  );

  always #5 clk = ~clk;

  // Behavioural universal shift register (no reset of its own).
  logic [W-1:0] reg_a = '0;
  always @(posedge clk) begin
    case (s)
      MODE_SHR:  reg_a <= {SR, reg_a[W-1:1]};
      MODE_SHL:  reg_a <= {reg_a[W-2:0], SL};
      MODE_LOAD: reg_a <= i;
      default:   reg_a <= reg_a;
    endcase
  end
  assign sr_out = reg_a[0];
  assign sl_out = reg_a[W-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: apply min(cnt,W) single-bit shifts to the word, recording each exiting bit.
  // Latency counts edges with the accept edge as the first.
  function automatic void model(input logic [W-1:0] d, input logic dir, input logic rot,
                                input logic fill, input logic [CW-1:0] cnt,
                                output logic [W-1:0] a, output logic [W-1:0] ser,
                                output int lat);
    int n;
    logic b;
    n = int'(cnt);
    if (n > W) n = W;
    a = d;
    ser = '0;
    for (int k = 0; k < n; k++) begin
      if (!dir) begin
        b = a[0];
        a = {(rot ? b : fill), a[W-1:1]};
      end else begin
        b = a[W-1];
        a = {a[W-2:0], (rot ? b : fill)};
      end
      ser[k] = b;
    end
    lat = n + 2;
  endfunction

  // Wait (bounded) at negedges until done; lat counts posedges incl. accept edge.
  task automatic wait_done(inout int lat);
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // Run one job from IDLE; scrambles inputs while busy. Called at a negedge.
  task automatic run_job(input logic [W-1:0] d, input logic dir, input logic rot,
                         input logic fill, input logic [CW-1:0] c,
                         output logic [W-1:0] a, output logic [W-1:0] ser, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_job", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_dir = dir; in_rot = rot; in_fill = fill; in_cnt = c;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; in_data = ~d; in_dir = ~dir; in_rot = ~rot; in_fill = ~fill;
    in_cnt = c ^ CW'(5);
    chk("load_mode", 32'(s), 32'(MODE_LOAD));
    chk("load_i", 32'(i), 32'(d));
    chk("accept_clears_ser", 32'(ser_data), 32'd0);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_not_ready", 32'(in_ready), 32'd0);
    wait_done(lat);
    chk("done_mode_hold", 32'(s), 32'(MODE_HOLD));
    a = reg_a;
    ser = ser_data;
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("ser_holds", 32'(ser_data), 32'(ser));
  endtask

  typedef struct {
    logic [W-1:0]  d;
    logic          dir;
    logic          rot;
    logic          fill;
    logic [CW-1:0] c;
    logic [W-1:0]  exp_a;
    logic [W-1:0]  exp_ser;
    int            exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [W-1:0]  a, ser, ma, mser;
    int            lat, mlat;
    logic [W-1:0]  bd[3];
    logic          bdir[3];
    logic [CW-1:0] bc[3];

    vecs[0] = '{4'b1011, 1'b0, 1'b0, 1'b0, 3'd4, 4'b0000, 4'b1011, 6};
    vecs[1] = '{4'b1011, 1'b0, 1'b1, 1'b0, 3'd4, 4'b1011, 4'b1011, 6};
    vecs[2] = '{4'b1011, 1'b1, 1'b0, 1'b1, 3'd2, 4'b1111, 4'b0001, 4};
    vecs[3] = '{4'b0110, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0110, 4'b0000, 2};
    vecs[4] = '{4'b1011, 1'b0, 1'b0, 1'b0, 3'd7, 4'b0000, 4'b1011, 6};
    vecs[5] = '{4'b1001, 1'b1, 1'b1, 1'b0, 3'd1, 4'b0011, 4'b0001, 3};
    vecs[6] = '{4'b1001, 1'b0, 1'b0, 1'b1, 3'd3, 4'b1111, 4'b0001, 5};

    // Reset state.
    #2;
    chk("rst_state_s", 32'(s), 32'(MODE_HOLD));
    chk("rst_state_i", 32'(i), 32'd0);
    chk("rst_state_ser", 32'(ser_data), 32'd0);
    chk("rst_state_ready", 32'(in_ready), 32'd1);
    chk("rst_state_busy", 32'(busy), 32'd0);
    chk("rst_state_done", 32'(done), 32'd0);
    chk("rst_state_srsl", 32'({SR, SL}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      run_job(vecs[v].d, vecs[v].dir, vecs[v].rot, vecs[v].fill, vecs[v].c, a, ser, lat);
      chk($sformatf("vec%0d_reg", v), 32'(a), 32'(vecs[v].exp_a));
      chk($sformatf("vec%0d_ser", v), 32'(ser), 32'(vecs[v].exp_ser));
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
    end

    // SHIFT serial inputs: fill vs rotate, checked mid-shift.
    in_valid = 1'b1; in_data = 4'b0110; in_dir = 1'b0; in_rot = 1'b0; in_fill = 1'b1;
    in_cnt = 3'd3;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("shift_mode_right", 32'(s), 32'(MODE_SHR));
    chk("fill_sr_sl", 32'({SR, SL}), 32'b11);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("fill_job_done", 32'(done), 32'd1);
    chk("srsl_zero_in_done", 32'({SR, SL}), 32'd0);
    @(negedge clk);

    // Reset during the second SHIFT cycle aborts the job.
    in_valid = 1'b1; in_data = 4'b1011; in_dir = 1'b0; in_rot = 1'b0; in_fill = 1'b0;
    in_cnt = 3'd4;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("pre_abort_shift", 32'(s), 32'(MODE_SHR));
    chk("pre_abort_ser", 32'(ser_data), 32'b0001);
    reset = 1'b0;
    #1;
    chk("abort_s", 32'(s), 32'(MODE_HOLD));
    chk("abort_i", 32'(i), 32'd0);
    chk("abort_ser", 32'(ser_data), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_srsl", 32'({SR, SL}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_no_done_after", 32'(done), 32'd0);
    model(4'b0101, 1'b1, 1'b1, 1'b0, 3'd3, ma, mser, mlat);
    run_job(4'b0101, 1'b1, 1'b1, 1'b0, 3'd3, a, ser, lat);
    chk("post_abort_reg", 32'(a), 32'(ma));
    chk("post_abort_ser", 32'(ser), 32'(mser));
    chk("post_abort_lat", 32'(lat), 32'(mlat));

    // Back-to-back with in_valid held high; inputs scrambled while busy.
    bd[0] = 4'b1100; bdir[0] = 1'b0; bc[0] = 3'd2;
    bd[1] = 4'b0011; bdir[1] = 1'b1; bc[1] = 3'd3;
    bd[2] = 4'b1010; bdir[2] = 1'b0; bc[2] = 3'd0;
    in_valid = 1'b1; in_data = bd[0]; in_dir = bdir[0]; in_rot = 1'b1; in_fill = 1'b0;
    in_cnt = bc[0];
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      chk("b2b_load", 32'(s), 32'(MODE_LOAD));
      chk("b2b_load_i", 32'(i), 32'(bd[j]));
      in_data = ~bd[j]; in_dir = ~bdir[j]; in_cnt = bc[j] + CW'(1);
      wait_done(lat);
      model(bd[j], bdir[j], 1'b1, 1'b0, bc[j], ma, mser, mlat);
      chk("b2b_reg", 32'(reg_a), 32'(ma));
      chk("b2b_ser", 32'(ser_data), 32'(mser));
      chk("b2b_lat", 32'(lat), 32'(mlat));
      if (j < 2) begin
        in_data = bd[j+1]; in_dir = bdir[j+1]; in_cnt = bc[j+1];
      end
      @(posedge clk);
      @(negedge clk);
      chk("b2b_idle_gap", 32'(in_ready), 32'd1);
      if (j == 2) in_valid = 1'b0;
    end
    @(negedge clk);

    // Randomized jobs against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [W-1:0]  rd;
      logic          rdir, rrot, rfill;
      logic [CW-1:0] rc;
      rd = W'($urandom);
      rdir = 1'($urandom); rrot = 1'($urandom); rfill = 1'($urandom);
      rc = CW'($urandom);
      model(rd, rdir, rrot, rfill, rc, ma, mser, mlat);
      run_job(rd, rdir, rrot, rfill, rc, a, ser, lat);
      chk("rand_reg", 32'(a), 32'(ma));
      chk("rand_ser", 32'(ser), 32'(mser));
      chk("rand_lat", 32'(lat), 32'(mlat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
